// File: rtl/tx_word_feeder.sv
// Word FIFO feeding a two-lane byte transmitter, high byte first, using a
// Moore request/acknowledge handshake per lane with a sticky timeout error.
module tx_word_feeder #(
  parameter int DEPTH_LOG2  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [15:0]           WrData,
  input  logic                  WrEn,
  output logic                  Full,
  output logic                  Empty,
  output logic [DEPTH_LOG2:0]   Count,
  output logic [15:0]           Data,
  output logic [1:0]            LatchData,
  input  logic [1:0]            Busy,
  output logic                  InFlight,
  output logic                  TxError
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  // Timer counts from 0, so the last permitted request cycle is ACK_TIMEOUT-1.
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HI_FREE = 3'd1,
    HI_REQ  = 3'd2,
    LO_FREE = 3'd3,
    LO_REQ  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic [15:0]           timer;
  logic                  push, pop, timed_out, tx_fail, req_entry;

  // A full FIFO drops the write even when a pop frees a slot this cycle.
  assign push      = WrEn && !Full;
  assign pop       = (state == IDLE) && (Count != '0);
  assign timed_out = (timer == TIMEOUT_LAST);
  assign req_entry = ((state_next == HI_REQ) && (state != HI_REQ)) ||
                     ((state_next == LO_REQ) && (state != LO_REQ));

  always_comb begin
    count_next = Count;
    case ({push, pop})
      2'b10:   count_next = Count + CNT_ONE;
      2'b01:   count_next = Count - CNT_ONE;
      default: count_next = Count;
    endcase
  end

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; an acknowledge wins over a coincident timeout.
  always_comb begin
    state_next = state;
    tx_fail    = 1'b0;
    case (state)
      IDLE:    if (pop) state_next = HI_FREE;
      HI_FREE: if (!Busy[1]) state_next = HI_REQ;
      HI_REQ: begin
        if (Busy[1]) begin
          state_next = LO_FREE;
        end else if (timed_out) begin
          state_next = LO_FREE;
          tx_fail    = 1'b1;
        end
      end
      LO_FREE: if (!Busy[0]) state_next = LO_REQ;
      LO_REQ: begin
        if (Busy[0]) begin
          state_next = IDLE;
        end else if (timed_out) begin
          state_next = IDLE;
          tx_fail    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    LatchData = 2'b00;
    InFlight  = 1'b1;
    case (state)
      IDLE:    InFlight  = 1'b0;
      HI_REQ:  LatchData = 2'b10;
      LO_REQ:  LatchData = 2'b01;
      default: LatchData = 2'b00;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      Count   <= '0;
      Full    <= 1'b0;
      Empty   <= 1'b1;
      timer   <= '0;
      TxError <= 1'b0;
      Data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        Data   <= mem[rd_ptr];
      end
      Count <= count_next;
      Full  <= (count_next == FULL_COUNT);
      Empty <= (count_next == '0);
      if (req_entry)
        timer <= '0;
      else if ((state == HI_REQ) || (state == LO_REQ))
        timer <= timer + 16'd1;
      if (tx_fail) TxError <= 1'b1;
    end
  end

  // Storage is not reset; only the pointers and count define its contents.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= WrData;
  end

endmodule

// File: tb/tb_tx_word_feeder.sv
// Directed bench for tx_word_feeder with an inline transmit-wrapper model.
module tb_tx_word_feeder;

  logic        Clock;
  logic        Reset;
  logic [15:0] WrData;
  logic        WrEn;
  logic        Full;
  logic        Empty;
  logic [2:0]  Count;
  logic [15:0] Data;
  logic [1:0]  LatchData;
  logic [1:0]  Busy;
  logic        InFlight;
  logic        TxError;

  int vectors = 0;
  int miscompares = 0;

  // Wrapper model state: Busy rises one cycle after a request rises, held `hold` cycles.
  bit       wrap_en = 0;
  int       hold = 10;
  int       busy_cnt [2] = '{0, 0};
  logic [1:0] lat_old = 2'b00;

  tx_word_feeder #(.DEPTH_LOG2(2), .ACK_TIMEOUT(8)) dut (
    .Clock(Clock), .Reset(Reset), .WrData(WrData), .WrEn(WrEn),
    .Full(Full), .Empty(Empty), .Count(Count), .Data(Data),
    .LatchData(LatchData), .Busy(Busy), .InFlight(InFlight), .TxError(TxError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] lat_prev;
    logic [1:0] rise;
    lat_prev = LatchData;
    rise     = lat_prev & ~lat_old;
    lat_old  = lat_prev;
    @(posedge Clock);
    #1;
    if (wrap_en) begin
      for (int i = 0; i < 2; i++) begin
        if (busy_cnt[i] != 0) busy_cnt[i]--;
        if (rise[i] && busy_cnt[i] == 0) busy_cnt[i] = hold;
      end
      Busy = {busy_cnt[1] != 0, busy_cnt[0] != 0};
    end
  endtask

  logic [15:0] t2_w [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
  int          t2_cnt [6] = '{1, 1, 2, 3, 4, 4};
  bit          t2_full [6] = '{0, 0, 0, 0, 1, 1};
  logic [15:0] t5_w [10] = '{16'h5A00, 16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04,
                             16'h5A05, 16'h5A06, 16'h5A07, 16'h5A08, 16'h5A09};

  initial begin
    int k;
    int nw;
    bit sim;
    logic [1:0] prev;

    Reset = 1'b0; WrEn = 1'b0; WrData = 16'h0000; Busy = 2'b00;

    // Reset and single word with wrapper (Busy held 10 cycles)
    wrap_en = 1; hold = 10;
    tick(); tick();
    Reset = 1'b1;
    chk("rst_data", Data, 16'h0000);
    chk("rst_latch", LatchData, 2'b00);
    chk("rst_full", Full, 1'b0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_inflight", InFlight, 1'b0);
    chk("rst_txerror", TxError, 1'b0);
    chk("rst_count", Count, 3'd0);
    WrData = 16'hF0AA; WrEn = 1'b1;
    tick(); WrEn = 1'b0;
    chk("t1_count1", Count, 3'd1);
    chk("t1_notempty", Empty, 1'b0);
    chk("t1_latch_n", LatchData, 2'b00);
    tick();
    chk("t1_data", Data, 16'hF0AA);
    chk("t1_inflight", InFlight, 1'b1);
    chk("t1_latch_free", LatchData, 2'b00);
    chk("t1_count0", Count, 3'd0);
    tick(); chk("t1_hi_a", LatchData, 2'b10);
    tick(); chk("t1_hi_b", LatchData, 2'b10);
    tick(); chk("t1_lofree", LatchData, 2'b00);
    tick(); chk("t1_lo_a", LatchData, 2'b01);
    tick(); chk("t1_lo_b", LatchData, 2'b01);
    tick();
    chk("t1_idle", LatchData, 2'b00);
    chk("t1_done", InFlight, 1'b0);
    chk("t1_txerror", TxError, 1'b0);

    // Fill and overflow with both lanes busy
    wrap_en = 0; busy_cnt = '{0, 0}; Busy = 2'b11;
    for (int i = 0; i < 6; i++) begin
      WrData = t2_w[i]; WrEn = 1'b1;
      tick();
      chk("t2_count", Count, t2_cnt[i]);
      chk("t2_full", Full, t2_full[i]);
    end
    WrEn = 1'b0;
    chk("t2_inflight_data", Data, 16'h1111);
    chk("t2_no_req", LatchData, 2'b00);
    hold = 1; wrap_en = 1; Busy = 2'b00;
    k = 0; prev = LatchData;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (LatchData == 2'b10 && prev != 2'b10) begin
        if (k < 5) chk("t2_order", Data, t2_w[k]);
        k++;
      end
      prev = LatchData;
    end
    chk("t2_nwords", k, 5);
    chk("t2_count_end", Count, 3'd0);
    chk("t2_empty_end", Empty, 1'b1);
    chk("t2_full_end", Full, 1'b0);
    chk("t2_idle_end", InFlight, 1'b0);

    // Lane ordering: lane 1 busy at word load
    wrap_en = 0; busy_cnt = '{0, 0}; Busy = 2'b10;
    WrData = 16'hA5C3; WrEn = 1'b1;
    tick(); WrEn = 1'b0;
    chk("t3_count", Count, 3'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_wait", LatchData, 2'b00);
    end
    chk("t3_data", Data, 16'hA5C3);
    Busy = 2'b00;
    tick(); chk("t3_hi_a", LatchData, 2'b10);
    tick(); chk("t3_hi_b", LatchData, 2'b10);
    Busy = 2'b10;
    tick(); chk("t3_lofree", LatchData, 2'b00);
    Busy = 2'b00;
    tick(); chk("t3_lo", LatchData, 2'b01);
    Busy = 2'b01;
    tick();
    chk("t3_idle", LatchData, 2'b00);
    chk("t3_done", InFlight, 1'b0);
    chk("t3_txerror", TxError, 1'b0);
    Busy = 2'b00;

    // Timeout with both lanes never acknowledging (ACK_TIMEOUT = 8)
    WrData = 16'h1234; WrEn = 1'b1;
    tick(); WrEn = 1'b0;
    tick(); chk("t4_free", LatchData, 2'b00);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_hi_hold", LatchData, 2'b10);
      chk("t4_err_pre", TxError, 1'b0);
    end
    tick();
    chk("t4_hi_drop", LatchData, 2'b00);
    chk("t4_err_set", TxError, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_lo_hold", LatchData, 2'b01);
    end
    tick();
    chk("t4_idle", LatchData, 2'b00);
    chk("t4_done", InFlight, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_err_sticky", TxError, 1'b1);

    // Simultaneous write and pop, pointer wrap over 10 words
    Busy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      WrData = t5_w[i]; WrEn = 1'b1;
      tick();
    end
    WrEn = 1'b0;
    chk("t5_count_pre", Count, 3'd2);
    chk("t5_data0", Data, t5_w[0]);
    busy_cnt = '{0, 0}; hold = 1; wrap_en = 1; Busy = 2'b00;
    nw = 3; k = 0; prev = LatchData;
    for (int c = 0; c < 300 && k < 10; c++) begin
      sim = 0;
      if (InFlight == 1'b0 && Count == 3'd2 && nw < 10) begin
        WrData = t5_w[nw]; WrEn = 1'b1; nw++; sim = 1;
      end
      tick();
      WrEn = 1'b0;
      if (sim) begin
        chk("t5_count_hold", Count, 3'd2);
        chk("t5_popped", InFlight, 1'b1);
      end
      if (LatchData == 2'b10 && prev != 2'b10) begin
        if (k < 10) chk("t5_order", Data, t5_w[k]);
        k++;
      end
      prev = LatchData;
    end
    chk("t5_nwords", k, 10);
    chk("t5_nwrites", nw, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_empty", Empty, 1'b1);
    chk("t5_count_end", Count, 3'd0);
    chk("t5_idle", InFlight, 1'b0);

    // Reset during LO_REQ with a word queued
    wrap_en = 0; busy_cnt = '{0, 0}; Busy = 2'b00;
    WrData = 16'hBEEF; WrEn = 1'b1;
    tick();
    WrData = 16'hCAFE;
    tick(); WrEn = 1'b0;
    chk("t6_count", Count, 3'd1);
    tick(); chk("t6_hi", LatchData, 2'b10);
    Busy = 2'b10;
    tick();
    Busy = 2'b00;
    tick();
    chk("t6_lo", LatchData, 2'b01);
    chk("t6_err_sticky", TxError, 1'b1);
    Reset = 1'b0;
    tick();
    chk("t6_latch", LatchData, 2'b00);
    chk("t6_count0", Count, 3'd0);
    chk("t6_empty", Empty, 1'b1);
    chk("t6_inflight", InFlight, 1'b0);
    chk("t6_err_clr", TxError, 1'b0);
    chk("t6_data", Data, 16'h0000);
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_quiet", LatchData, 2'b00);
    end
    chk("t6_count_end", Count, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
